// File: rtl/gray_pkg.sv
// gray_pkg: shared Gray-code helpers for the counter library.
//   bin2gray - binary to reflected Gray code (any width up to GRAY_MAX_W, zero-extended).
//   gray2bin - Gray to binary, MSB-first prefix XOR.
//   max_val  - all-ones value for a given width.
package gray_pkg;

  localparam int unsigned GRAY_MAX_W = 32;

  function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Upper bits are zero for narrow callers, so the prefix XOR is unaffected.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  function automatic logic [GRAY_MAX_W-1:0] max_val(input int unsigned w);
    return (w >= GRAY_MAX_W) ? '1 : ((GRAY_MAX_W'(1) << w) - 1'b1);
  endfunction

endpackage

// File: rtl/gray_to_bin_n.sv
// gray_to_bin_n: purely combinational WIDTH-bit Gray-to-binary converter.
//   i_gray  [WIDTH-1:0]  Gray-coded input
//   o_bin   [WIDTH-1:0]  binary equivalent
module gray_to_bin_n
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_gray,
  output logic [WIDTH-1:0] o_bin
);

  assign o_bin = WIDTH'(gray2bin(GRAY_MAX_W'(i_gray)));

endmodule

// File: rtl/gray_updown_counter.sv
// gray_updown_counter: up/down binary counter with registered binary and Gray
// outputs, Gray-coded preset, wrap or saturate at the limits.
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         count enable (one step per cycle)
//   up_dn      1 = increment, 0 = decrement
//   load       preset strobe (beats en)
//   load_gray  Gray-coded preset value
//   bin_q      registered binary count
//   gray_q     registered Gray code of bin_q
//   tc         terminal count for the live direction (combinational from bin_q)
//   wrap       one-cycle pulse on wrap / blocked step past a limit
module gray_updown_counter
  import gray_pkg::*;
#(
  parameter int unsigned      WIDTH   = 4,
  parameter bit               WRAP_EN = 1'b1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_gray,
  output logic [WIDTH-1:0] bin_q,
  output logic [WIDTH-1:0] gray_q,
  output logic             tc,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_BIN  = WIDTH'(max_val(WIDTH));
  localparam logic [WIDTH-1:0] RST_GRAY = RST_VAL ^ (RST_VAL >> 1);

  logic [WIDTH-1:0] r_bin, r_gray;
  logic             r_wrap;
  logic [WIDTH-1:0] w_load_bin, w_next_bin, w_next_gray;
  logic             w_next_wrap, w_tc;

  gray_to_bin_n #(.WIDTH(WIDTH)) u_g2b (
    .i_gray (load_gray),
    .o_bin  (w_load_bin)
  );

  // At the limit for the current direction; doubles as the wrap/overflow condition.
  assign w_tc = up_dn ? (r_bin == MAX_BIN) : (r_bin == '0);

  always_comb begin
    w_next_bin  = r_bin;
    w_next_wrap = 1'b0;
    if (load) begin
      w_next_bin = w_load_bin;
    end else if (en) begin
      w_next_wrap = w_tc;
      // Saturating mode holds at the limit; otherwise WIDTH-bit arithmetic wraps.
      if (!(w_tc && !WRAP_EN))
        w_next_bin = up_dn ? (r_bin + 1'b1) : (r_bin - 1'b1);
    end
    // Gray follows next_bin so it never lags bin_q.
    w_next_gray = load ? load_gray : WIDTH'(bin2gray(GRAY_MAX_W'(w_next_bin)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin  <= RST_VAL;
      r_gray <= RST_GRAY;
      r_wrap <= 1'b0;
    end else begin
      r_bin  <= w_next_bin;
      r_gray <= w_next_gray;
      r_wrap <= w_next_wrap;
    end
  end

  assign bin_q  = r_bin;
  assign gray_q = r_gray;
  assign wrap   = r_wrap;
  assign tc     = w_tc;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Scoreboard bench: four counter configurations share one stimulus stream;
// a reference model pushes expected outputs, a negedge monitor pops and checks.
module tb_gray_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, up_dn, load;
  logic [7:0] load_gray;

  logic [3:0] b0, g0, b1, g1;
  logic [7:0] b2, g2, b3, g3;
  logic       tc0, tc1, tc2, tc3, w0, w1, w2, w3;

  gray_updown_counter #(.WIDTH(4), .WRAP_EN(1'b1), .RST_VAL(4'd0)) u_w4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray[3:0]),
    .bin_q(b0), .gray_q(g0), .tc(tc0), .wrap(w0));
  gray_updown_counter #(.WIDTH(4), .WRAP_EN(1'b0), .RST_VAL(4'd15)) u_s4 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray[3:0]),
    .bin_q(b1), .gray_q(g1), .tc(tc1), .wrap(w1));
  gray_updown_counter #(.WIDTH(8), .WRAP_EN(1'b1), .RST_VAL(8'hA5)) u_w8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .bin_q(b2), .gray_q(g2), .tc(tc2), .wrap(w2));
  gray_updown_counter #(.WIDTH(8), .WRAP_EN(1'b0), .RST_VAL(8'h00)) u_s8 (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .load_gray(load_gray),
    .bin_q(b3), .gray_q(g3), .tc(tc3), .wrap(w3));

  logic [7:0] ab[4], ag[4];
  logic       at[4], aw[4];
  assign ab[0] = {4'h0, b0}; assign ag[0] = {4'h0, g0}; assign at[0] = tc0; assign aw[0] = w0;
  assign ab[1] = {4'h0, b1}; assign ag[1] = {4'h0, g1}; assign at[1] = tc1; assign aw[1] = w1;
  assign ab[2] = b2;         assign ag[2] = g2;         assign at[2] = tc2; assign aw[2] = w2;
  assign ab[3] = b3;         assign ag[3] = g3;         assign at[3] = tc3; assign aw[3] = w3;

  int W[4]  = '{4, 4, 8, 8};
  bit WR[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
  int RV[4] = '{0, 15, 'hA5, 0};
  int m_bin[4] = '{0, 0, 0, 0};

  typedef struct {
    int idx;
    int bin;
    int gray;
    int tc;
    int wrap;
    bit cnt;   // count step (en without load/rst)
    int chg;   // expected number of Gray bits flipping on that step
  } exp_t;

  exp_t sbq[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   pg[4] = '{0, 0, 0, 0};

  function automatic void chk(string name, int idx, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s inst%0d at %0t: got %0h expected %0h", name, idx, $time, act, exp);
    end
  endfunction

  // Preset decode by search: the binary whose Gray code matches.
  function automatic int g2b(int g, int mask);
    for (int b = 0; b <= mask; b++) if ((b ^ (b >> 1)) == g) return b;
    return -1;
  endfunction

  task automatic cyc(bit r, bit e, bit u, bit l, logic [7:0] g);
    @(negedge clk);
    #1;
    rst = r; en = e; up_dn = u; load = l; load_gray = g;
    for (int k = 0; k < 4; k++) begin
      int   mask;
      int   nb;
      exp_t x;
      mask = (1 << W[k]) - 1;
      nb = m_bin[k];
      x.wrap = 0;
      x.cnt = 1'b0;
      if (r) nb = RV[k];
      else if (l) nb = g2b(int'(g) & mask, mask);
      else if (e) begin
        x.cnt = 1'b1;
        if (u) begin
          if (nb == mask) begin x.wrap = 1; nb = WR[k] ? 0 : mask; end
          else nb = nb + 1;
        end else begin
          if (nb == 0) begin x.wrap = 1; nb = WR[k] ? mask : 0; end
          else nb = nb - 1;
        end
      end
      x.idx  = k;
      x.bin  = nb;
      x.gray = nb ^ (nb >> 1);
      x.tc   = u ? int'(nb == mask) : int'(nb == 0);
      x.chg  = (nb != m_bin[k]) ? 1 : 0;
      m_bin[k] = nb;
      sbq.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    while (sbq.size() > 0) begin
      exp_t x;
      x = sbq.pop_front();
      chk("bin_q",  x.idx, int'(ab[x.idx]), x.bin);
      chk("gray_q", x.idx, int'(ag[x.idx]), x.gray);
      chk("tc",     x.idx, int'(at[x.idx]), x.tc);
      chk("wrap",   x.idx, int'(aw[x.idx]), x.wrap);
      if (x.cnt) chk("gray_step", x.idx, $countones(int'(ag[x.idx]) ^ pg[x.idx]), x.chg);
      pg[x.idx] = int'(ag[x.idx]);
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; up_dn = 1'b0; load = 1'b0; load_gray = '0;
    // reset, down direction: tc high at 0
    cyc(1, 0, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    // 17 up steps: full 4-bit wrap
    for (int i = 0; i < 17; i++) cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 0, 1, 0, 8'h00);
    // Gray preset 1101 -> 9, then step down
    cyc(0, 0, 0, 1, 8'b0000_1101);
    cyc(0, 1, 0, 0, 8'h00);
    // preset 1000 -> 15, push past top, then turn around
    cyc(0, 0, 1, 1, 8'b0000_1000);
    for (int i = 0; i < 3; i++) cyc(0, 1, 1, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    // priority: rst over load/en, then load over en
    cyc(1, 1, 1, 1, 8'hFF);
    cyc(0, 1, 1, 1, 8'b0000_0110);
    // down past zero
    cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(0, 0, 0, 0, 8'h00);
    // random sweep
    for (int i = 0; i < 1000; i++)
      cyc($urandom_range(63) == 0, $urandom_range(3) != 0, $urandom_range(1) == 1,
          $urandom_range(7) == 0, 8'($urandom));
    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", 0, sbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
